// File: rtl/cas_sort_pipe.sv
// cas_sort_pipe: N-stage odd-even transposition sorter, one register per stage.
// Every vector carries its own sort order (desc) and a running count of exchanges.
// By the last stage that count equals the vector's inversion count.

// One compare-and-swap cell. y0 gets the lower-indexed lane.
module cas_sort_cell #(
    parameter int WIDTH = 6
) (
    input  logic             desc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             swap
);
    // Swap only on a strict inversion, so equal values stay in place.
    assign swap = desc ? (a < b) : (a > b);
    assign y0   = swap ? b : a;
    assign y1   = swap ? a : b;
endmodule

module cas_sort_pipe #(
    parameter int WIDTH = 6,
    parameter int N     = 4,
    localparam int CW   = $clog2(N*(N-1)/2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    output logic [N*WIDTH-1:0]   out_data,
    output logic                 out_desc,
    output logic [CW-1:0]        out_swaps
);
    // Array index order: [stage][lane]. Lane k maps to bits [k*WIDTH +: WIDTH].
    logic [N-1:0][N-1:0][WIDTH-1:0] stg_in, nxt, q_data;
    logic [N-1:0]                   stg_desc, q_desc, vld_pipe;
    logic [N-1:0][CW-1:0]           stg_cnt, cnt_nxt, q_cnt;
    logic [N-1:0][N/2-1:0]          swp;

    for (genvar s = 0; s < N; s++) begin : g_stage
        // Stage 0 takes its input from the ports. Later stages take the previous stage's registers.
        if (s == 0) begin : g_head
            assign stg_in[s]   = in_data;
            assign stg_desc[s] = in_desc;
            assign stg_cnt[s]  = '0;
        end else begin : g_body
            assign stg_in[s]   = q_data[s-1];
            assign stg_desc[s] = q_desc[s-1];
            assign stg_cnt[s]  = q_cnt[s-1];
        end

        // Even stages pair (0,1),(2,3),... and odd stages pair (1,2),...,(N-3,N-2).
        // In odd stages the last pair slot has no partner. That slot passes lanes 0 and N-1 through.
        for (genvar i = 0; i < N/2; i++) begin : g_pair
            localparam int P = (s % 2) + 2*i;
            if (P + 1 < N) begin : g_cas
                cas_sort_cell #(.WIDTH(WIDTH)) u_cas (
                    .desc (stg_desc[s]),
                    .a    (stg_in[s][P]),
                    .b    (stg_in[s][P+1]),
                    .y0   (nxt[s][P]),
                    .y1   (nxt[s][P+1]),
                    .swap (swp[s][i])
                );
            end else begin : g_pass
                assign nxt[s][0]   = stg_in[s][0];
                assign nxt[s][N-1] = stg_in[s][N-1];
                assign swp[s][i]   = 1'b0;
            end
        end
    end

    // Add this stage's exchange count to the running count. The total never exceeds N*(N-1)/2, so it never wraps.
    always_comb begin
        cnt_nxt = '0;
        for (int s = 0; s < N; s++) begin
            cnt_nxt[s] = stg_cnt[s];
            for (int i = 0; i < N/2; i++)
                cnt_nxt[s] = cnt_nxt[s] + CW'(swp[s][i]);
        end
    end

    // Advance the pipeline on en. Reset clears every stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data   <= '0;
            q_desc   <= '0;
            q_cnt    <= '0;
            vld_pipe <= '0;
        end else if (en) begin
            q_data   <= nxt;
            q_desc   <= stg_desc;
            q_cnt    <= cnt_nxt;
            vld_pipe <= {vld_pipe[N-2:0], in_valid};
        end
    end

    assign out_valid = vld_pipe[N-1];
    assign out_data  = q_data[N-1];
    assign out_desc  = q_desc[N-1];
    assign out_swaps = q_cnt[N-1];
endmodule

// File: tb/tb_cas_sort_pipe.sv
// Bench for cas_sort_pipe with N=4 and WIDTH=6.
// It runs table vectors, a stall, a mid-flight reset and a random stream against a scoreboard.
module tb_cas_sort_pipe;
    localparam int N = 4;
    localparam int W = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_desc = 1'b0;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_desc;
    logic [2:0]  out_swaps;

    cas_sort_pipe #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid),
        .out_data(out_data), .out_desc(out_desc), .out_swaps(out_swaps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic        dsc;
        logic [23:0] ed;
        logic [2:0]  es;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        dsc;
        logic [2:0]  s;
        int          tag;
    } exp_t;

    exp_t  sbq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    ecnt = 0;
    bit    last_en = 1'b0;
    logic [28:0] snap = '0;

    function automatic logic [23:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[5:0], l2[5:0], l1[5:0], l0[5:0]};
    endfunction

    // Reference: brute-force inversion count plus a selection sort.
    function automatic void ref_sort(input logic [23:0] d, input logic dsc,
                                     output logic [23:0] o, output logic [2:0] s);
        int a[4];
        int c;
        int t;
        c = 0;
        for (int i = 0; i < 4; i++) a[i] = int'(d[i*6 +: 6]);
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (dsc ? (a[i] < a[j]) : (a[i] > a[j])) c++;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (dsc ? (a[j] > a[i]) : (a[j] < a[i])) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
        o = pk(a[0], a[1], a[2], a[3]);
        s = c[2:0];
    endfunction

    // Drive one cycle. The scoreboard entry is pushed at the edge that accepts the vector.
    task automatic cyc(input logic [23:0] d, input logic dsc, input logic v, input logic e,
                       input logic [23:0] ed, input logic [2:0] es);
        exp_t x;
        in_data = d; in_desc = dsc; in_valid = v; en = e;
        @(posedge clk);
        last_en = e;
        if (e && rst_n) begin
            ecnt++;
            if (v) begin
                x.d = ed; x.dsc = dsc; x.s = es; x.tag = ecnt;
                sbq.push_back(x);
            end
        end
        #1;
    endtask

    task automatic cyc_ref(input logic [23:0] d, input logic dsc, input logic v, input logic e);
        logic [23:0] o;
        logic [2:0]  s;
        ref_sort(d, dsc, o, s);
        cyc(d, dsc, v, e, o, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 3'd0);
    endtask

    // Monitor on the falling edge. Checks order, latency, freeze under en low, and spurious or missing out_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!last_en) begin
                    n_cmp++;
                    if ({out_valid, out_data, out_desc, out_swaps} !== snap) begin
                        n_err++;
                        $display("FAIL freeze: got %h, want %h", {out_valid, out_data, out_desc, out_swaps}, snap);
                    end
                end else if (out_valid) begin
                    n_cmp++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL spurious_valid: got out_valid=1 data=%h at ecnt=%0d, want out_valid=0", out_data, ecnt);
                    end else begin
                        e = sbq.pop_front();
                        if (out_data !== e.d || out_desc !== e.dsc || out_swaps !== e.s || ecnt != e.tag + N - 1) begin
                            n_err++;
                            $display("FAIL result: got data=%h desc=%b swaps=%0d ecnt=%0d, want data=%h desc=%b swaps=%0d ecnt=%0d",
                                     out_data, out_desc, out_swaps, ecnt, e.d, e.dsc, e.s, e.tag + N - 1);
                        end
                        if (out_desc) begin
                            n_cmp++;
                            for (int k = 0; k < 3; k++)
                                if (out_data[(k+1)*6 +: 6] > out_data[k*6 +: 6]) begin
                                    n_err++;
                                    $display("FAIL desc_order: got lane%0d=%0d > lane%0d=%0d, want non-increasing",
                                             k + 1, out_data[(k+1)*6 +: 6], k, out_data[k*6 +: 6]);
                                end
                        end
                    end
                end else if (sbq.size() > 0 && ecnt >= sbq[0].tag + N - 1) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_valid: got out_valid=0 at ecnt=%0d, want result tagged %0d", ecnt, sbq[0].tag);
                    void'(sbq.pop_front());
                end
            end
            snap = {out_valid, out_data, out_desc, out_swaps};
        end
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{pk(3, 7, 1, 5),     1'b1, pk(7, 5, 3, 1),     3'd3};
        tbl[1] = '{pk(3, 7, 1, 5),     1'b0, pk(1, 3, 5, 7),     3'd3};
        tbl[2] = '{pk(9, 9, 9, 9),     1'b1, pk(9, 9, 9, 9),     3'd0};
        tbl[3] = '{pk(0, 63, 0, 63),   1'b1, pk(63, 63, 0, 0),   3'd3};
        tbl[4] = '{pk(63, 62, 61, 60), 1'b0, pk(60, 61, 62, 63), 3'd6};

        // Check the reset state before any clock edge.
        #2;
        n_cmp++;
        if ({out_valid, out_data, out_desc, out_swaps} !== 29'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h, want 0", {out_valid, out_data, out_desc, out_swaps});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);

        // A single isolated vector, then the whole table back-to-back.
        cyc(tbl[0].d, tbl[0].dsc, 1'b1, 1'b1, tbl[0].ed, tbl[0].es);
        idle(6);
        for (int i = 0; i < 5; i++) cyc(tbl[i].d, tbl[i].dsc, 1'b1, 1'b1, tbl[i].ed, tbl[i].es);
        idle(6);

        // Stall: en is low for 3 cycles after the 2nd vector enters. Inputs offered during the stall must be ignored.
        cyc_ref(pk(5, 1, 4, 2), 1'b1, 1'b1, 1'b1);
        cyc_ref(pk(10, 20, 30, 40), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc_ref(pk(33, 44, 11, 22), 1'b0, 1'b1, 1'b0);
        cyc_ref(pk(8, 2, 6, 4), 1'b0, 1'b1, 1'b1);
        cyc_ref(pk(1, 2, 3, 4), 1'b1, 1'b1, 1'b1);
        idle(6);

        // Mid-cycle reset with 3 vectors in flight.
        cyc_ref(pk(1, 9, 2, 8), 1'b1, 1'b1, 1'b1);
        cyc_ref(pk(4, 3, 2, 1), 1'b0, 1'b1, 1'b1);
        cyc_ref(pk(7, 7, 0, 1), 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_desc, out_swaps} !== 29'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h, want 0", {out_valid, out_data, out_desc, out_swaps});
        end
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);
        cyc_ref(pk(12, 40, 3, 3), 1'b1, 1'b1, 1'b1);
        idle(6);

        // Random stream: random data, order, valid and en.
        for (int i = 0; i < 1000; i++)
            cyc_ref(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) != 0));
        idle(8);

        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cas_sort_pipe.md
CAS_SORT_PIPE -- requirements
Module: cas_sort_pipe

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 6: unsigned bit width of each lane value.
REQ-002 The block SHALL have parameter N, default 4: lane count, even, N >= 2.
REQ-003 The block SHALL have derived localparam CW = clog2(N*(N-1)/2 + 1): swap-count width (3 for N=4).

Interface
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  pipeline advance enable; low = every register holds.
REQ-007 in_valid  input  1  in_data/in_desc carry a vector this cycle.
REQ-008 in_data  input  N*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
REQ-009 in_desc  input  1  sort order: 1 = descending (lane 0 largest), 0 = ascending (lane 0 smallest).
REQ-010 out_valid  output  1  out_data/out_desc/out_swaps are a sorted result.
REQ-011 out_data  output  N*WIDTH  sorted vector, same lane packing.
REQ-012 out_desc  output  1  in_desc value that travelled with the vector.
REQ-013 out_swaps  output  CW  number of exchanges performed on the vector.

Function
REQ-014 Structure SHALL be an N-stage odd-even transposition network, one register stage per network stage.
REQ-015 Even stages (0,2,..) SHALL compare lane pairs (0,1),(2,3),...; odd stages SHALL compare (1,2),(3,4),...,(N-3,N-2); lanes 0 and N-1 pass through unchanged in odd stages.
REQ-016 Comparisons SHALL be unsigned over WIDTH bits.
REQ-017 Each compare-and-swap SHALL exchange the pair only when strictly out of order for that vector's desc bit; equal values SHALL never swap.
REQ-018 Every stage SHALL register data, valid, desc and a running swap count, incremented by the number of swaps made in that stage.
REQ-019 With en high every cycle, latency SHALL be exactly N cycles: a vector presented at edge t appears on the outputs after edge t+N-1 (N register stages).
REQ-020 Throughput SHALL be one vector per cycle while en is high; vectors SHALL leave in arrival order.
REQ-021 in_valid low SHALL inject a bubble; bubble slots carry valid=0 and their data/count are don't-care.
REQ-022 en low SHALL freeze all stages (data, valid, desc, count) including outputs; inputs presented while en is low SHALL be ignored, not lost-in-flight vectors.
REQ-023 desc SHALL be per-vector: vectors of mixed order may be interleaved back-to-back with no penalty.
REQ-024 out_swaps SHALL equal the inversion count of the input under the requested order, at most N*(N-1)/2; it SHALL never wrap.
REQ-025 Outputs SHALL be driven directly from the final stage registers (no combinational input-to-output path).

Reset
REQ-026 rst_n low SHALL immediately, without a clock, clear all stage valid bits, data, desc and counts to 0; out_valid=0, out_data=0, out_desc=0, out_swaps=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight vectors; none SHALL emerge after release.
REQ-028 After rst_n rises, the first vector accepted SHALL emerge N cycles later with no spurious out_valid before it.

Verification (N=4, WIDTH=6, en=1 unless stated)
REQ-029 in_data lanes {3,7,1,5}, in_desc=1, in_valid pulse -> 4 cycles later out_valid=1 for one cycle, out_data {7,5,3,1}, out_desc=1, out_swaps=3.
REQ-030 Same lanes, in_desc=0 -> {1,3,5,7}, out_desc=0, out_swaps=3; the two vectors sent back-to-back emerge on consecutive cycles in order.
REQ-031 Boundaries: {9,9,9,9} desc=1 -> {9,9,9,9}, swaps=0; {0,63,0,63} desc=1 -> {63,63,0,0}, swaps=3; {63,62,61,60} desc=0 -> {60,61,62,63}, swaps=6.
REQ-032 Stream 4 vectors, drop en for 3 cycles after the 2nd enters -> outputs frozen during stall, all 4 emerge in order, no duplicate or lost out_valid.
REQ-033 rst_n pulsed low asynchronously (mid-cycle) with 3 vectors in flight -> outputs 0 at once, no out_valid afterward until a new vector is sent, which emerges 4 cycles later.
REQ-034 1000 random vectors, random in_desc, random in_valid and en -> every output matches a reference sort and inversion count; in descending results no lane k+1 exceeds lane k.
